// File: rtl/xbar_cfg.sv
// Config-loadable crossbar: word-serial shadow load, atomic commit, registered outputs.
// Optional selector readback port enabled by defining XBAR_CFG_READBACK_EN.
module xbar_cfg #(
  parameter int unsigned N_IN  = 21,
  parameter int unsigned N_OUT = 24,
  parameter int unsigned SEL_W = 5,
  parameter int unsigned CFG_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IN-1:0]    io_xbar_in,
  output logic [N_OUT-1:0]   io_xbar_out,
  input  logic               io_cfg_valid,
  output logic               io_cfg_ready,
  input  logic [CFG_W-1:0]   io_cfg_data,
  input  logic               io_cfg_commit,
  input  logic               io_cfg_abort,
  output logic               io_cfg_full,
  output logic               io_cfg_err
`ifdef XBAR_CFG_READBACK_EN
  ,
  input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] io_rd_idx,
  output logic [SEL_W-1:0]   io_rd_sel
`endif
);

  localparam int unsigned TOTAL    = N_OUT * SEL_W;
  localparam int unsigned NWORDS   = (TOTAL + CFG_W - 1) / CFG_W;
  localparam int unsigned SHADOW_W = NWORDS * CFG_W;
  localparam int unsigned CNT_W    = $clog2(NWORDS + 1);
  localparam int unsigned SEL_N    = 2 ** SEL_W;

  localparam logic ST_LOAD = 1'b0;
  localparam logic ST_FULL = 1'b1;

  logic                state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0]    active_q, active_d;
  logic                err_q,    err_d;
  logic [N_OUT-1:0]    out_q,    out_d;
  logic                accept_c;
  logic [SEL_N-1:0]    in_ext_c;

  assign io_cfg_ready = (state_q == ST_LOAD) && reset;
  assign accept_c     = io_cfg_valid && io_cfg_ready;

  // Config FSM: abort wins; commit acts on the pre-edge state; words shift in from the top.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    if (io_cfg_abort) begin
      cnt_d   = '0;
      state_d = ST_LOAD;
      err_d   = 1'b0;
    end else begin
      if (io_cfg_commit) begin
        if (state_q == ST_FULL) begin
          active_d = shadow_q[TOTAL-1:0];
          cnt_d    = '0;
          state_d  = ST_LOAD;
        end else begin
          err_d = 1'b1;
        end
      end
      if (accept_c) begin
        shadow_d = SHADOW_W'({io_cfg_data, shadow_q} >> CFG_W);
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NWORDS - 1)) begin
          state_d = ST_FULL;
        end
      end
    end
  end

  // Inputs zero-extended to the full selector range so out-of-range selectors read 0.
  always_comb begin
    in_ext_c = '0;
    in_ext_c[N_IN-1:0] = io_xbar_in;
    out_d = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      out_d[k] = in_ext_c[active_q[k*SEL_W +: SEL_W]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
      out_q    <= out_d;
    end
  end

  assign io_xbar_out = out_q;
  assign io_cfg_full = (state_q == ST_FULL);
  assign io_cfg_err  = err_q;

`ifdef XBAR_CFG_READBACK_EN
  localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [SEL_W-1:0] rd_tab [2**IDX_W];
  logic [SEL_W-1:0] rd_sel_q, rd_sel_d;

  // Table padded to the full index range; indices past N_OUT read 0.
  for (genvar g = 0; g < int'(2**IDX_W); g++) begin : g_rd_tab
    if (g < int'(N_OUT)) begin : g_used
      assign rd_tab[g] = active_q[g*SEL_W +: SEL_W];
    end else begin : g_pad
      assign rd_tab[g] = '0;
    end
  end

  assign rd_sel_d = rd_tab[io_rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_sel_q <= '0;
    end else begin
      rd_sel_q <= rd_sel_d;
    end
  end

  assign io_rd_sel = rd_sel_q;
`endif

endmodule

// File: tb/tb_xbar_cfg.sv
// Self-checking bench for xbar_cfg: word-level reference model plus directed literal checks.
module tb_xbar_cfg;
  localparam int unsigned N_IN   = 21;
  localparam int unsigned N_OUT  = 24;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned CFG_W  = 8;
  localparam int unsigned TOTAL  = N_OUT * SEL_W;
  localparam int unsigned NWORDS = (TOTAL + CFG_W - 1) / CFG_W;
  localparam int unsigned IDX_W  = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N_IN-1:0]   io_xbar_in = '0;
  logic [N_OUT-1:0]  io_xbar_out;
  logic              io_cfg_valid = 1'b0;
  logic              io_cfg_ready;
  logic [CFG_W-1:0]  io_cfg_data = '0;
  logic              io_cfg_commit = 1'b0;
  logic              io_cfg_abort = 1'b0;
  logic              io_cfg_full;
  logic              io_cfg_err;
`ifdef XBAR_CFG_READBACK_EN
  logic [IDX_W-1:0]  io_rd_idx = '0;
  logic [SEL_W-1:0]  io_rd_sel;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  xbar_cfg #(.N_IN(N_IN), .N_OUT(N_OUT), .SEL_W(SEL_W), .CFG_W(CFG_W)) dut (
    .clk(clk), .reset(reset),
    .io_xbar_in(io_xbar_in), .io_xbar_out(io_xbar_out),
    .io_cfg_valid(io_cfg_valid), .io_cfg_ready(io_cfg_ready), .io_cfg_data(io_cfg_data),
    .io_cfg_commit(io_cfg_commit), .io_cfg_abort(io_cfg_abort),
    .io_cfg_full(io_cfg_full), .io_cfg_err(io_cfg_err)
`ifdef XBAR_CFG_READBACK_EN
    , .io_rd_idx(io_rd_idx), .io_rd_sel(io_rd_sel)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accepted words kept by index, selectors decoded on commit.
  int               m_active [N_OUT];
  int               m_words  [NWORDS];
  int               m_cnt;
  bit               m_full, m_err;
  logic [N_OUT-1:0] exp_out;
  logic [SEL_W-1:0] exp_rd;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(N_OUT); k++) m_active[k] = 0;
      for (int i = 0; i < int'(NWORDS); i++) m_words[i] = 0;
      m_cnt = 0; m_full = 0; m_err = 0;
      exp_out = '0; exp_rd = '0;
    end else begin
      bit was_full;
      logic [31:0] inw;
      was_full = m_full;
      inw = 32'(io_xbar_in);
      exp_out = '0;
      for (int k = 0; k < int'(N_OUT); k++)
        if (((inw >> m_active[k]) & 32'd1) == 32'd1) exp_out = exp_out | (N_OUT'(1) << k);
`ifdef XBAR_CFG_READBACK_EN
      exp_rd = (int'(io_rd_idx) < int'(N_OUT)) ? SEL_W'(m_active[io_rd_idx]) : '0;
`endif
      if (io_cfg_abort) begin
        m_cnt = 0; m_full = 0; m_err = 0;
      end else begin
        if (io_cfg_commit) begin
          if (was_full) begin
            for (int k = 0; k < int'(N_OUT); k++) begin
              int s;
              s = 0;
              for (int j = 0; j < int'(SEL_W); j++) begin
                int b;
                b = k * int'(SEL_W) + j;
                s = s | (((m_words[b / int'(CFG_W)] >> (b % int'(CFG_W))) & 1) << j);
              end
              m_active[k] = s;
            end
            m_cnt = 0; m_full = 0;
          end else begin
            m_err = 1;
          end
        end
        if (io_cfg_valid && !was_full) begin
          m_words[m_cnt] = int'(io_cfg_data);
          m_cnt++;
          if (m_cnt == int'(NWORDS)) m_full = 1;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (reset) begin
      chk("model_out", 64'(io_xbar_out), 64'(exp_out));
      chk("model_ready", 64'(io_cfg_ready), 64'(!m_full));
      chk("model_full", 64'(io_cfg_full), 64'(m_full));
      chk("model_err", 64'(io_cfg_err), 64'(m_err));
`ifdef XBAR_CFG_READBACK_EN
      chk("model_rd_sel", 64'(io_rd_sel), 64'(exp_rd));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(input logic [TOTAL-1:0] cfg, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      io_cfg_valid = 1'b1;
      io_cfg_data  = CFG_W'(cfg >> (i * int'(CFG_W)));
      tick();
    end
    io_cfg_valid = 1'b0;
  endtask

  task automatic do_commit();
    io_cfg_commit = 1'b1;
    tick();
    io_cfg_commit = 1'b0;
  endtask

  task automatic rand_in(input int n);
    for (int i = 0; i < n; i++) begin
      io_xbar_in = N_IN'($urandom);
      tick();
    end
  endtask

  // mode 0: sel_k = 20-k / k-21; mode 1: sel_k = k / k-21; mode 2: sel_0 = 31, rest 0
  function automatic logic [TOTAL-1:0] build(input int mode);
    logic [TOTAL-1:0] cfg;
    int s;
    cfg = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      case (mode)
        0:       s = (k <= 20) ? 20 - k : k - 21;
        1:       s = (k <= 20) ? k : k - 21;
        default: s = (k == 0) ? 31 : 0;
      endcase
      cfg = cfg | (TOTAL'(s) << (k * int'(SEL_W)));
    end
    return cfg;
  endfunction

  logic [TOTAL-1:0] cfg_a, cfg_b, cfg_c;

  initial begin
    cfg_a = build(0);
    cfg_b = build(1);
    cfg_c = build(2);
    #2 reset = 1'b0;
    tick();
    chk("rst_out", 64'(io_xbar_out), 64'h0);
    chk("rst_full", 64'(io_cfg_full), 64'h0);
    chk("rst_err", 64'(io_cfg_err), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    io_xbar_in = 21'h1;
    tick();
    chk("t1_out_all_in0", 64'(io_xbar_out), 64'hFFFFFF);
    chk("t1_ready", 64'(io_cfg_ready), 64'h1);
    chk("t1_full", 64'(io_cfg_full), 64'h0);
    chk("t1_err", 64'(io_cfg_err), 64'h0);

    // Full load and commit timing
    send_range(cfg_a, 0, int'(NWORDS));
    chk("t2_full", 64'(io_cfg_full), 64'h1);
    chk("t2_ready", 64'(io_cfg_ready), 64'h0);
    io_xbar_in = 21'h100000;
    do_commit();
    chk("t2_out_old_cfg", 64'(io_xbar_out), 64'h0);
    chk("t2_full_clr", 64'(io_cfg_full), 64'h0);
    tick();
    chk("t2_out_new_cfg", 64'(io_xbar_out), 64'h000001);
    rand_in(6);

    // Extra word while full is refused
    send_range(cfg_b, 0, int'(NWORDS));
    io_cfg_valid = 1'b1;
    io_cfg_data  = 8'hAA;
    tick();
    chk("t3_ready_full", 64'(io_cfg_ready), 64'h0);
    chk("t3_full_hold", 64'(io_cfg_full), 64'h1);
    io_cfg_valid = 1'b0;
    io_xbar_in = 21'h3;
    do_commit();
    chk("t3_full_after", 64'(io_cfg_full), 64'h0);
    chk("t3_ready_after", 64'(io_cfg_ready), 64'h1);
    tick();
    chk("t3_out", 64'(io_xbar_out), 64'h600003);
    rand_in(6);

    // Premature commit, commit with accept, abort with accept
    io_xbar_in = 21'h3;
    send_range(cfg_a, 0, 7);
    do_commit();
    chk("t4_err_set", 64'(io_cfg_err), 64'h1);
    tick();
    chk("t4_active_kept", 64'(io_xbar_out), 64'h600003);
    io_cfg_valid = 1'b1;
    io_cfg_data  = CFG_W'(cfg_a >> (7 * int'(CFG_W)));
    do_commit();
    io_cfg_abort = 1'b1;
    tick();
    io_cfg_abort = 1'b0;
    io_cfg_valid = 1'b0;
    chk("t4_err_clr", 64'(io_cfg_err), 64'h0);
    chk("t4_ready", 64'(io_cfg_ready), 64'h1);
    send_range(cfg_a, 0, int'(NWORDS));
    chk("t4_full", 64'(io_cfg_full), 64'h1);
    io_xbar_in = 21'h100000;
    do_commit();
    tick();
    chk("t4_out", 64'(io_xbar_out), 64'h000001);
    rand_in(4);

    // Out-of-range selector
    send_range(cfg_c, 0, int'(NWORDS));
    io_xbar_in = '1;
    do_commit();
    tick();
    chk("t5_out_oor", 64'(io_xbar_out), 64'hFFFFFE);
    rand_in(4);

    // Reset mid-load
    send_range(cfg_b, 0, 9);
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_out", 64'(io_xbar_out), 64'h0);
    chk("t6_rst_full", 64'(io_cfg_full), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    send_range(cfg_a, 0, int'(NWORDS) - 1);
    chk("t6_not_full_14", 64'(io_cfg_full), 64'h0);
    send_range(cfg_a, int'(NWORDS) - 1, int'(NWORDS));
    chk("t6_full_15", 64'(io_cfg_full), 64'h1);
`ifdef XBAR_CFG_READBACK_EN
    io_rd_idx = 5'd3;
`endif
    do_commit();
`ifdef XBAR_CFG_READBACK_EN
    chk("t6_rd_old", 64'(io_rd_sel), 64'h0);
`endif
    tick();
`ifdef XBAR_CFG_READBACK_EN
    chk("t6_rd_sel3", 64'(io_rd_sel), 64'd17);
    io_rd_idx = 5'd30;
    tick();
    chk("t6_rd_oor", 64'(io_rd_sel), 64'h0);
`endif
    rand_in(6);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
